// File: rtl/pif_flash_pkg.sv
// -----------------------------------------------------------------------------
// pif_flash_pkg
// Shared definitions for the PIF LED flash decoder:
//   - phase encoding of the 4-phase breathing sequence
//   - FSM state encoding of the phase tracker
//   - default measurement window (26.6 MHz oscillator / 150 Hz tick)
//   - legal_step(): true when a candidate phase holds or advances by one
// -----------------------------------------------------------------------------
package pif_flash_pkg;

  localparam int WIN_LEN_DEF = 26600000 / 150;

  localparam logic [1:0] PH_RED_UP = 2'd0;
  localparam logic [1:0] PH_RED_DN = 2'd1;
  localparam logic [1:0] PH_GRN_UP = 2'd2;
  localparam logic [1:0] PH_GRN_DN = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  // The breathing sequence only ever stays put or moves one phase forward,
  // wrapping from green-down back to red-up.
  function automatic logic legal_step(input logic [1:0] cur, input logic [1:0] cand);
    logic [1:0] nxt;
    nxt = cur + 2'd1;
    return (cand == cur) || (cand == nxt);
  endfunction

endpackage

// File: rtl/pif_duty_window.sv
// -----------------------------------------------------------------------------
// pif_duty_window
// Counts how many clocks each LED was on inside a fixed window of WIN_LEN
// clocks and publishes the totals once per window.
// Ports:
//   Clk, RstN           clock, synchronous active-low reset
//   red_on, green_on    sampled LED state, active-high
//   done                high for the cycle in which tot_r/tot_g hold a full
//                       window (the duty registers load on the next edge)
//   tot_r, tot_g        running accumulators (complete totals while done=1)
//   red_duty, green_duty totals of the last completed window
//   dv                  one-cycle pulse, duty outputs just updated
// -----------------------------------------------------------------------------
module pif_duty_window
  import pif_flash_pkg::*;
#(
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int CW      = $clog2(WIN_LEN + 1)
) (
  input  logic          Clk,
  input  logic          RstN,
  input  logic          red_on,
  input  logic          green_on,
  output logic          done,
  output logic [CW-1:0] tot_r,
  output logic [CW-1:0] tot_g,
  output logic [CW-1:0] red_duty,
  output logic [CW-1:0] green_duty,
  output logic          dv
);

  localparam int WCW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [WCW-1:0] WC_LAST = WCW'(WIN_LEN - 1);

  logic [WCW-1:0] wc;
  logic           last_q;
  logic [CW-1:0]  acc_r;
  logic [CW-1:0]  acc_g;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      wc         <= '0;
      last_q     <= 1'b0;
      acc_r      <= '0;
      acc_g      <= '0;
      red_duty   <= '0;
      green_duty <= '0;
      dv         <= 1'b0;
    end else begin
      wc     <= (wc == WC_LAST) ? '0 : wc + WCW'(1);
      last_q <= (wc == WC_LAST);
      dv     <= last_q;
      if (last_q) begin
        // Accumulators already hold the full window (last sample included);
        // publish them and restart with this cycle's sample so none is lost.
        red_duty   <= acc_r;
        green_duty <= acc_g;
        acc_r      <= CW'(red_on);
        acc_g      <= CW'(green_on);
      end else begin
        acc_r <= acc_r + CW'(red_on);
        acc_g <= acc_g + CW'(green_on);
      end
    end
  end

  assign done  = last_q;
  assign tot_r = acc_r;
  assign tot_g = acc_g;

endmodule

// File: rtl/pif_flash_decoder.sv
// -----------------------------------------------------------------------------
// pif_flash_decoder
// Receive-side monitor for the PIF red/green LED flasher. Measures per-window
// on-time of each LED, recovers the breathing phase (red up, red down,
// green up, green down) and flags both LEDs being on together.
// Ports:
//   Clk, RstN            LED clock, synchronous active-low reset
//   red_n, green_n       LED drives, active-low
//   red_duty, green_duty on-clocks in the last completed window
//   dv                   one-cycle pulse when duties/phase/locked update
//   phase                0 red up, 1 red down, 2 green up, 3 green down
//   locked               phase decode is stable
//   err                  sticky, both LEDs seen on in the same cycle
// Build option:
//   PIF_FLASHDEC_SYNC_EN  adds a 2-flop synchronizer (reset to LED off) on
//                         each LED input; adds 2 cycles of input latency.
// -----------------------------------------------------------------------------
module pif_flash_decoder
  import pif_flash_pkg::*;
#(
  parameter int WIN_LEN  = WIN_LEN_DEF,
  parameter int CW       = $clog2(WIN_LEN + 1),
  parameter int LOCK_CNT = 2
) (
  input  logic          Clk,
  input  logic          RstN,
  input  logic          red_n,
  input  logic          green_n,
  output logic [CW-1:0] red_duty,
  output logic [CW-1:0] green_duty,
  output logic          dv,
  output logic [1:0]    phase,
  output logic          locked,
  output logic          err
);

  localparam int LCW = $clog2(LOCK_CNT + 1);

  logic red_on;
  logic green_on;

`ifdef PIF_FLASHDEC_SYNC_EN
  logic [1:0] red_sync;
  logic [1:0] green_sync;

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      red_sync   <= 2'b11;
      green_sync <= 2'b11;
    end else begin
      red_sync   <= {red_sync[0], red_n};
      green_sync <= {green_sync[0], green_n};
    end
  end

  assign red_on   = ~red_sync[1];
  assign green_on = ~green_sync[1];
`else
  assign red_on   = ~red_n;
  assign green_on = ~green_n;
`endif

  logic          done;
  logic [CW-1:0] tot_r;
  logic [CW-1:0] tot_g;

  pif_duty_window #(
    .WIN_LEN (WIN_LEN),
    .CW      (CW)
  ) u_window (
    .Clk        (Clk),
    .RstN       (RstN),
    .red_on     (red_on),
    .green_on   (green_on),
    .done       (done),
    .tot_r      (tot_r),
    .tot_g      (tot_g),
    .red_duty   (red_duty),
    .green_duty (green_duty),
    .dv         (dv)
  );

  state_t         state;
  logic [CW-1:0]  prev_r;
  logic [CW-1:0]  prev_g;
  logic [LCW-1:0] lock_cnt;

  // Candidate phase from the window that is about to be published.
  logic [1:0]     cand;
  logic           decode;
  logic           legal;
  logic [LCW-1:0] cnt_inc;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cand   = PH_RED_UP;
    decode = 1'b0;
    if (tot_r > tot_g) begin
      if (tot_r > prev_r) begin
        cand   = PH_RED_UP;
        decode = 1'b1;
      end else if (tot_r < prev_r) begin
        cand   = PH_RED_DN;
        decode = 1'b1;
      end
    end else if (tot_g > tot_r) begin
      if (tot_g > prev_g) begin
        cand   = PH_GRN_UP;
        decode = 1'b1;
      end else if (tot_g < prev_g) begin
        cand   = PH_GRN_DN;
        decode = 1'b1;
      end
    end
  end

  assign legal   = legal_step(phase, cand);
  assign cnt_inc = (lock_cnt == LCW'(LOCK_CNT)) ? lock_cnt : lock_cnt + LCW'(1);

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state    <= S_IDLE;
      prev_r   <= '0;
      prev_g   <= '0;
      lock_cnt <= '0;
      phase    <= PH_RED_UP;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (red_on && green_on) err <= 1'b1;

      // Acting on 'done' makes phase/locked change on the same edge as dv.
      if (done) begin
        prev_r <= tot_r;
        prev_g <= tot_g;
        case (state)
          S_IDLE: state <= S_TRACK;

          S_TRACK: begin
            if (decode) begin
              phase <= cand;
              if (legal) begin
                lock_cnt <= cnt_inc;
                if (cnt_inc >= LCW'(LOCK_CNT)) begin
                  state  <= S_LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                lock_cnt <= '0;
              end
            end
          end

          S_LOCKED: begin
            if (decode) begin
              phase <= cand;
              if (legal) begin
                lock_cnt <= cnt_inc;
              end else begin
                lock_cnt <= '0;
                locked   <= 1'b0;
                state    <= S_TRACK;
              end
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pif_flash_decoder.sv
// -----------------------------------------------------------------------------
// tb_pif_flash_decoder
// Self-checking bench for pif_flash_decoder with WIN_LEN=8. Windows are built
// from per-window on-counts (directed breathing sequence, then random), and a
// reference model recomputes duties, phase, lock and err per window.
// -----------------------------------------------------------------------------
module tb_pif_flash_decoder;

  localparam int W    = 8;
  localparam int CW   = $clog2(W + 1);
  localparam int LOCK = 2;
`ifdef PIF_FLASHDEC_SYNC_EN
  localparam int LAT  = 2;
`else
  localparam int LAT  = 0;
`endif
  localparam int MAXS = 600;
  localparam int NDIR = 15;

  logic          Clk;
  logic          RstN;
  logic          red_n;
  logic          green_n;
  logic [CW-1:0] red_duty;
  logic [CW-1:0] green_duty;
  logic          dv;
  logic [1:0]    phase;
  logic          locked;
  logic          err;

  pif_flash_decoder #(
    .WIN_LEN  (W),
    .CW       (CW),
    .LOCK_CNT (LOCK)
  ) dut (
    .Clk        (Clk),
    .RstN       (RstN),
    .red_n      (red_n),
    .green_n    (green_n),
    .red_duty   (red_duty),
    .green_duty (green_duty),
    .dv         (dv),
    .phase      (phase),
    .locked     (locked),
    .err        (err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus: per-slot LED on bits (slot 1 = first sampled edge after reset).
  bit stim_r [MAXS];
  bit stim_g [MAXS];
  bit drv_r  [MAXS];
  bit drv_g  [MAXS];
  int win_r  [64];
  int win_g  [64];

  // Reference model state.
  bit m_first;
  int m_ph, m_cnt, m_pr, m_pg;
  bit m_lk, m_err;
  bit directed;

  // Directed breathing sequence and the phase/lock it must produce.
  int dir_r  [NDIR] = '{1, 2, 3, 5, 4, 3, 0, 0, 0, 0, 0, 1, 2, 3, 0};
  int dir_g  [NDIR] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 3, 0, 0, 2, 1};
  int dir_ph [NDIR] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 0, 0, 0, 3};
  int dir_lk [NDIR] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

  task automatic clear_stim();
    for (int i = 0; i < MAXS; i++) begin
      stim_r[i] = 1'b0;
      stim_g[i] = 1'b0;
    end
  endtask

  // Lay out r red and g green on-cycles (r+g <= W) in window k without overlap.
  task automatic put_window(input int k, input int r, input int g, input bit shuffle);
    int pos [W];
    int j, t;
    for (int i = 0; i < W; i++) pos[i] = i;
    if (shuffle) begin
      for (int i = W - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = pos[i]; pos[i] = pos[j]; pos[j] = t;
      end
    end
    for (int i = 0; i < g; i++) stim_g[k*W + pos[i] + 1] = 1'b1;
    for (int i = W - r; i < W; i++) stim_r[k*W + pos[i] + 1] = 1'b1;
  endtask

  task automatic put_random(input int k);
    int r, g;
    r = $urandom_range(0, W);
    g = $urandom_range(0, W - r);
    put_window(k, r, g, 1'b1);
  endtask

  task automatic model_reset();
    m_first = 1'b1;
    m_ph = 0; m_cnt = 0; m_pr = 0; m_pg = 0;
    m_lk = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 64; i++) begin
      win_r[i] = 0;
      win_g[i] = 0;
    end
  endtask

  // Phase tracking straight from the rules: dominant LED, trend, legal step.
  task automatic model_window(input int r, input int g);
    int  cand;
    bit  legal;
    cand = -1;
    if (m_first) begin
      m_first = 1'b0;
    end else begin
      if (r > g)      cand = (r > m_pr) ? 0 : (r < m_pr) ? 1 : -1;
      else if (g > r) cand = (g > m_pg) ? 2 : (g < m_pg) ? 3 : -1;
      if (cand >= 0) begin
        legal = (cand == m_ph) || (cand == (m_ph + 1) % 4);
        m_ph  = cand;
        if (legal) begin
          if (m_cnt < LOCK) m_cnt++;
          if (m_cnt >= LOCK) m_lk = 1'b1;
        end else begin
          m_cnt = 0;
          m_lk  = 1'b0;
        end
      end
    end
    m_pr = r;
    m_pg = g;
  endtask

  task automatic do_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge Clk);
      RstN    = 1'b0;
      red_n   = 1'($urandom_range(0, 1));
      green_n = 1'($urandom_range(0, 1));
      @(posedge Clk);
      #1;
      check("rst_dv", dv, 0);
      check("rst_red_duty", red_duty, 0);
      check("rst_green_duty", green_duty, 0);
      check("rst_phase", phase, 0);
      check("rst_locked", locked, 0);
      check("rst_err", err, 0);
    end
    model_reset();
  endtask

  // Release reset and run nslots sampled edges, checking every edge.
  task automatic run(input int nslots);
    bit sr, sg, exp_dv;
    int k;
    for (int n = 1; n <= nslots; n++) begin
      @(negedge Clk);
      RstN     = 1'b1;
      drv_r[n] = stim_r[n + LAT];
      drv_g[n] = stim_g[n + LAT];
      red_n    = ~drv_r[n];
      green_n  = ~drv_g[n];
      @(posedge Clk);
      #1;
      sr = (n > LAT) ? drv_r[n - LAT] : 1'b0;
      sg = (n > LAT) ? drv_g[n - LAT] : 1'b0;
      exp_dv = (n >= W + 1) && ((n - 1) % W == 0);
      check("dv", dv, exp_dv);
      if (exp_dv) begin
        k = (n - W - 1) / W;
        model_window(win_r[k], win_g[k]);
        check("red_duty", red_duty, win_r[k]);
        check("green_duty", green_duty, win_g[k]);
        check("phase", phase, m_ph);
        check("locked", locked, m_lk);
        if (directed && k < NDIR && (k == 2 || k == 4 || k == 6 || k == 10 || k == 11 || k == 14)) begin
          check("dir_phase", phase, dir_ph[k]);
          check("dir_locked", locked, dir_lk[k]);
        end
      end
      k = (n - 1) / W;
      win_r[k] += int'(sr);
      win_g[k] += int'(sg);
      if (sr && sg) m_err = 1'b1;
      check("err", err, m_err);
    end
  endtask

  initial begin
    RstN    = 1'b0;
    red_n   = 1'b1;
    green_n = 1'b1;
    directed = 1'b0;

    // Reset with toggling inputs.
    do_reset(5);

    // Directed breathing sequence, random windows, an overlap window, a tail.
    clear_stim();
    for (int k = 0; k < NDIR; k++) put_window(k, dir_r[k], dir_g[k], 1'b0);
    for (int k = NDIR; k < NDIR + 20; k++) put_random(k);
    stim_r[(NDIR + 20) * W + 4] = 1'b1;
    stim_g[(NDIR + 20) * W + 4] = 1'b1;
    put_random(NDIR + 21);
    directed = 1'b1;
    run((NDIR + 22) * W + 1);
    directed = 1'b0;
    check("err_sticky", err, 1);

    // Reset mid-window: partial window discarded, err cleared.
    clear_stim();
    for (int k = 0; k < 4; k++) put_random(k);
    do_reset(1);
    run(3);
    do_reset(3);
    clear_stim();
    for (int k = 0; k < 4; k++) put_random(k);
    run(4 * W + 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
